// File: rtl/general_register_pkg.sv
// rtl/general_register_pkg.sv - shared types and access-size decode for the GPR write scheduler
package general_register_pkg;

  typedef logic [2:0] register_index_t;
  typedef logic [3:0] byte_enable_t;

  typedef enum logic [1:0] {
    SIZE_8,
    SIZE_16,
    SIZE_32
  } access_size_e;

  localparam register_index_t REG_EAX = 3'd0;
  localparam register_index_t REG_ECX = 3'd1;
  localparam register_index_t REG_EDX = 3'd2;
  localparam register_index_t REG_EBX = 3'd3;
  localparam register_index_t REG_ESP = 3'd4;
  localparam register_index_t REG_EBP = 3'd5;
  localparam register_index_t REG_ESI = 3'd6;
  localparam register_index_t REG_EDI = 3'd7;

  // A w bit only narrows the access when the instruction actually carries one.
  function automatic access_size_e decode_access_size(input logic w,
                                                      input logic w_in_instruction,
                                                      input logic operand_size_32);
    if (w_in_instruction && !w) return SIZE_8;
    else if (operand_size_32)   return SIZE_32;
    else                        return SIZE_16;
  endfunction

endpackage

// File: rtl/general_register_lane_map.sv
// rtl/general_register_lane_map.sv - maps a reg code and access size onto a physical register, lanes and data
module general_register_lane_map
  import general_register_pkg::*;
(
  input  logic [2:0]      register_code_i,
  input  logic            w_i,
  input  logic            w_in_instruction_i,
  input  logic            operand_size_32_i,
  input  logic [31:0]     data_i,
  output register_index_t index_o,
  output byte_enable_t    byte_enable_o,
  output logic [31:0]     aligned_data_o
);

  access_size_e size;

  always_comb begin
    size           = decode_access_size(w_i, w_in_instruction_i, operand_size_32_i);
    index_o        = register_code_i;
    byte_enable_o  = '0;
    aligned_data_o = '0;
    case (size)
      SIZE_8: begin
        // Codes 4-7 in byte mode are the high bytes of EAX..EBX.
        if (!register_code_i[2]) begin
          byte_enable_o       = 4'b0001;
          aligned_data_o[7:0] = data_i[7:0];
        end else begin
          index_o              = {1'b0, register_code_i[1:0]};
          byte_enable_o        = 4'b0010;
          aligned_data_o[15:8] = data_i[7:0];
        end
      end
      SIZE_16: begin
        byte_enable_o        = 4'b0011;
        aligned_data_o[15:0] = data_i[15:0];
      end
      default: begin
        byte_enable_o  = 4'b1111;
        aligned_data_o = data_i;
      end
    endcase
  end

endmodule

// File: rtl/general_register_write_scheduler.sv
// rtl/general_register_write_scheduler.sv - round-robin arbiter and one-entry write stage for the GPR file
module general_register_write_scheduler
  import general_register_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3*NUM_REQ-1:0]          req_register_code,
  input  logic [NUM_REQ-1:0]            req_w,
  input  logic [NUM_REQ-1:0]            req_w_in_instruction,
  input  logic [NUM_REQ-1:0]            req_operand_size_32,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  input  logic                          rf_write_stall,
  output logic                          rf_write_enable,
  output logic [2:0]                    rf_write_index,
  output logic [3:0]                    rf_write_byte_enable,
  output logic [DATA_WIDTH-1:0]         rf_write_data,
  input  logic [2:0]                    query_register_code,
  input  logic                          query_w,
  input  logic                          query_w_in_instruction,
  input  logic                          query_operand_size_32,
  output logic                          query_busy
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  register_index_t       req_index   [NUM_REQ];
  byte_enable_t          req_be      [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_aligned [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    general_register_lane_map u_lane_map (
      .register_code_i    (req_register_code[3*g +: 3]),
      .w_i                (req_w[g]),
      .w_in_instruction_i (req_w_in_instruction[g]),
      .operand_size_32_i  (req_operand_size_32[g]),
      .data_i             (req_data[DATA_WIDTH*g +: DATA_WIDTH]),
      .index_o            (req_index[g]),
      .byte_enable_o      (req_be[g]),
      .aligned_data_o     (req_aligned[g])
    );
  end

  register_index_t       query_index;
  byte_enable_t          query_be;
  logic [DATA_WIDTH-1:0] query_data_unused;

  general_register_lane_map u_query_lane_map (
    .register_code_i    (query_register_code),
    .w_i                (query_w),
    .w_in_instruction_i (query_w_in_instruction),
    .operand_size_32_i  (query_operand_size_32),
    .data_i             ('0),
    .index_o            (query_index),
    .byte_enable_o      (query_be),
    .aligned_data_o     (query_data_unused)
  );

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  stage_valid_q, stage_valid_d;
  register_index_t       stage_index_q, stage_index_d;
  byte_enable_t          stage_be_q, stage_be_d;
  logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_found;
  logic               stage_free;
  logic               accept;

  // Two passes give the rotation: first requesters at/after the pointer, then the wrap-around.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (PTR_W'(i) >= rr_ptr_q)) begin
        grant_found = 1'b1;
        grant[i]    = 1'b1;
        grant_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (PTR_W'(i) < rr_ptr_q)) begin
        grant_found = 1'b1;
        grant[i]    = 1'b1;
        grant_idx   = PTR_W'(i);
      end
    end
  end

  assign stage_free = !stage_valid_q || !rf_write_stall;
  assign accept     = grant_found && stage_free;
  assign req_ready  = grant & {NUM_REQ{stage_free}};

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    stage_valid_d = stage_valid_q;
    stage_index_d = stage_index_q;
    stage_be_d    = stage_be_q;
    stage_data_d  = stage_data_q;
    if (accept) begin
      rr_ptr_d      = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      stage_valid_d = 1'b1;
      stage_index_d = req_index[grant_idx];
      stage_be_d    = req_be[grant_idx];
      stage_data_d  = req_aligned[grant_idx];
    end else if (!rf_write_stall) begin
      stage_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q      <= '0;
      stage_valid_q <= 1'b0;
      stage_index_q <= '0;
      stage_be_q    <= '0;
      stage_data_q  <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      stage_valid_q <= stage_valid_d;
      stage_index_q <= stage_index_d;
      stage_be_q    <= stage_be_d;
      stage_data_q  <= stage_data_d;
    end
  end

  assign rf_write_enable      = stage_valid_q;
  assign rf_write_index       = stage_index_q;
  assign rf_write_byte_enable = stage_be_q;
  assign rf_write_data        = stage_data_q;

  assign query_busy = stage_valid_q && (query_index == stage_index_q) && |(query_be & stage_be_q);

endmodule

// File: tb/tb_general_register_write_scheduler.sv
// tb/tb_general_register_write_scheduler.sv - directed self-checking bench for the GPR write scheduler
module tb_general_register_write_scheduler;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  code0, code1;
  logic [1:0]  req_w, req_w_in, req_op32;
  logic [31:0] data0, data1;
  logic        rf_write_stall;
  logic        rf_write_enable;
  logic [2:0]  rf_write_index;
  logic [3:0]  rf_write_byte_enable;
  logic [31:0] rf_write_data;
  logic [2:0]  query_register_code;
  logic        query_w, query_w_in_instruction, query_operand_size_32;
  logic        query_busy;

  int checks = 0;
  int errors = 0;

  general_register_write_scheduler #(.NUM_REQ(2), .DATA_WIDTH(32)) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .req_register_code      ({code1, code0}),
    .req_w                  (req_w),
    .req_w_in_instruction   (req_w_in),
    .req_operand_size_32    (req_op32),
    .req_data               ({data1, data0}),
    .rf_write_stall         (rf_write_stall),
    .rf_write_enable        (rf_write_enable),
    .rf_write_index         (rf_write_index),
    .rf_write_byte_enable   (rf_write_byte_enable),
    .rf_write_data          (rf_write_data),
    .query_register_code    (query_register_code),
    .query_w                (query_w),
    .query_w_in_instruction (query_w_in_instruction),
    .query_operand_size_32  (query_operand_size_32),
    .query_busy             (query_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] code, input logic w, input logic w_in,
                         input logic op32, input logic [31:0] data);
    if (i == 0) begin
      code0 = code; req_w[0] = w; req_w_in[0] = w_in; req_op32[0] = op32; data0 = data;
    end else begin
      code1 = code; req_w[1] = w; req_w_in[1] = w_in; req_op32[1] = op32; data1 = data;
    end
  endtask

  task automatic query(input logic [2:0] code, input logic w, input logic w_in, input logic op32);
    query_register_code    = code;
    query_w                = w;
    query_w_in_instruction = w_in;
    query_operand_size_32  = op32;
    #1;
  endtask

  task automatic check_write(input string tag, input logic [2:0] idx, input logic [3:0] be,
                             input logic [31:0] data);
    check({tag, "_we"}, {31'd0, rf_write_enable}, 32'd1);
    check({tag, "_idx"}, {29'd0, rf_write_index}, {29'd0, idx});
    check({tag, "_be"}, {28'd0, rf_write_byte_enable}, {28'd0, be});
    check({tag, "_data"}, rf_write_data, data);
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = '0; req_w = '0; req_w_in = '0; req_op32 = '0;
    code0 = '0; code1 = '0; data0 = '0; data1 = '0;
    rf_write_stall = 1'b0;
    query_register_code = '0; query_w = 1'b0; query_w_in_instruction = 1'b0; query_operand_size_32 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_we", {31'd0, rf_write_enable}, 32'd0);
    check("rst_idx", {29'd0, rf_write_index}, 32'd0);
    check("rst_be", {28'd0, rf_write_byte_enable}, 32'd0);
    check("rst_data", rf_write_data, 32'd0);
    check("rst_busy", {31'd0, query_busy}, 32'd0);
    reset_n = 1'b1;

    // AH write from requester 0
    set_req(0, 3'd4, 1'b0, 1'b1, 1'b1, 32'h0000_00A5);
    req_valid = 2'b01;
    #1;
    check("ah_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    check_write("ah", 3'd0, 4'b0010, 32'h0000_A500);

    // 16-bit write to DI from requester 1
    set_req(1, 3'd7, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    req_valid = 2'b10;
    #1;
    check("w16_ready", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = 2'b00;
    check_write("w16", 3'd7, 4'b0011, 32'h0000_5678);

    // Alternating grants with both requesters valid
    set_req(0, 3'd1, 1'b1, 1'b1, 1'b1, 32'h1111_1111);
    set_req(1, 3'd5, 1'b1, 1'b1, 1'b1, 32'h2222_2222);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      if (k % 2 == 0) check_write("rr0", 3'd1, 4'b1111, 32'h1111_1111);
      else            check_write("rr1", 3'd5, 4'b1111, 32'h2222_2222);
    end
    req_valid = 2'b00;
    step();
    check("drain_we", {31'd0, rf_write_enable}, 32'd0);

    // EDX write held by a stall while both requesters wait
    set_req(0, 3'd2, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    req_valid = 2'b01;
    step();
    check_write("edx", 3'd2, 4'b1111, 32'hDEAD_BEEF);
    rf_write_stall = 1'b1;
    set_req(0, 3'd3, 1'b1, 1'b1, 1'b1, 32'h3333_3333);
    set_req(1, 3'd0, 1'b1, 1'b1, 1'b1, 32'h4444_4444);
    req_valid = 2'b11;
    query(3'd2, 1'b1, 1'b1, 1'b1);
    check("busy_edx", {31'd0, query_busy}, 32'd1);
    query(3'd6, 1'b0, 1'b1, 1'b1);
    check("busy_dh", {31'd0, query_busy}, 32'd1);
    query(3'd3, 1'b1, 1'b1, 1'b1);
    check("busy_ebx", {31'd0, query_busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("stall_ready", {30'd0, req_ready}, 32'd0);
      check_write("stall_hold", 3'd2, 4'b1111, 32'hDEAD_BEEF);
      step();
    end
    rf_write_stall = 1'b0;
    #1;
    check("unstall_ready", {30'd0, req_ready}, 32'd2);
    step();
    req_valid = 2'b01;
    check_write("unstall1", 3'd0, 4'b1111, 32'h4444_4444);
    #1;
    check("next_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    check_write("unstall0", 3'd3, 4'b1111, 32'h3333_3333);
    step();
    check("drain2_we", {31'd0, rf_write_enable}, 32'd0);

    // Pending AH write vs. AL and AX queries
    set_req(0, 3'd4, 1'b0, 1'b1, 1'b1, 32'h0000_005A);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    check_write("ah2", 3'd0, 4'b0010, 32'h0000_5A00);
    query(3'd0, 1'b0, 1'b1, 1'b1);
    check("busy_al", {31'd0, query_busy}, 32'd0);
    query(3'd0, 1'b1, 1'b0, 1'b0);
    check("busy_ax", {31'd0, query_busy}, 32'd1);
    step();

    // Reset while a stalled write is pending
    set_req(0, 3'd1, 1'b1, 1'b1, 1'b1, 32'hCAFE_F00D);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    rf_write_stall = 1'b1;
    check_write("pre_rst", 3'd1, 4'b1111, 32'hCAFE_F00D);
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, rf_write_enable}, 32'd0);
    check("mid_rst_be", {28'd0, rf_write_byte_enable}, 32'd0);
    check("mid_rst_data", rf_write_data, 32'd0);
    check("mid_rst_idx", {29'd0, rf_write_index}, 32'd0);
    reset_n = 1'b1;
    rf_write_stall = 1'b0;
    req_valid = 2'b11;
    #1;
    check("post_rst_ready", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    check_write("post_rst", 3'd1, 4'b1111, 32'hCAFE_F00D);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/general_register_write_scheduler.md
Name: general_register_write_scheduler

Overview:
- Shares the single general-register-file write port between N requesters, e.g. execute writeback and microcode/string unit.
- Decodes each request's 3-bit register code plus w / w_in_instruction / operand-size into a physical register index, byte enables and lane-aligned data.
- Holds the granted write in a one-entry output stage that the register file drains.
- Gives decode a combinational busy query so it can stall on a read-after-write hazard against the pending write.

Parameters:
NUM_REQ, 2, number of write requesters (2..4)
DATA_WIDTH, 32, register width; fixed at 32 for the 80386 datapath

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  requester has a write pending
req_ready  output  NUM_REQ  write accepted this cycle when valid&ready
req_register_code  input  3*NUM_REQ  reg/rm field per requester
req_w  input  NUM_REQ  w bit per requester
req_w_in_instruction  input  NUM_REQ  instruction carries a w bit
req_operand_size_32  input  NUM_REQ  full size is 32 (1) or 16 (0)
req_data  input  32*NUM_REQ  write data, LSB-aligned
rf_write_stall  input  1  register file cannot take the write this cycle
rf_write_enable  output  1  output stage holds a valid write
rf_write_index  output  3  physical register 0..7 (EAX..EDI)
rf_write_byte_enable  output  4  byte lanes written
rf_write_data  output  32  lane-aligned data, unused lanes zero
query_register_code  input  3  decode operand register code
query_w  input  1  decode operand w bit
query_w_in_instruction  input  1  decode operand has w bit
query_operand_size_32  input  1  decode operand size
query_busy  output  1  operand overlaps the pending write

Behaviour:
- Reset is asynchronous: stage_valid=0; rf_write_index=0, rf_write_byte_enable=0, rf_write_data=0; round-robin pointer selects requester 0 first.
- Size decode:
  - Byte access: w_in_instruction=1 and w=0.
  - Otherwise full access: 32-bit if operand_size_32=1, else 16-bit.
- Lane map:
  - Byte, code 0-3 (AL,CL,DL,BL): index=code, be=0001, data[7:0]=src[7:0].
  - Byte, code 4-7 (AH,CH,DH,BH): index=code-4, be=0010, data[15:8]=src[7:0].
  - 16-bit: index=code, be=0011, data[15:0].
  - 32-bit: index=code, be=1111, data[31:0].
  - All other data lanes are 0.
- Stage can load when stage_free = !stage_valid | !rf_write_stall.
- Arbitration:
  - Round-robin among valid requesters, starting at the requester after the last one accepted.
  - The grant is one-hot and combinational.
  - req_ready[i] = grant[i] & stage_free.
  - The pointer advances only on an accepted transfer.
  - Holding valid with a stalled stage does not rotate priority.
- Latency: request accepted in cycle T; rf_write_enable=1 in T+1 with the decoded index, byte enables and data.
- Stage update each clock:
  - Accept: load the stage, stage_valid=1. Back-to-back accepts are allowed when rf_write_stall=0 (one write per cycle).
  - No accept and !rf_write_stall: stage_valid=0.
  - rf_write_stall=1: stage and all rf_write_* outputs hold unchanged.
- Register-file contract: rf_write_enable=stage_valid. The register file commits in every cycle where rf_write_enable=1 and rf_write_stall=0.
- query_busy = stage_valid & (query index == rf_write_index) & |(query be & rf_write_byte_enable), using the same lane map. AL vs. a pending AH write is not busy; AX vs. a pending AH write is busy.
- No valid requester: all req_ready=0 and the stage drains.
- Asserting reset_n low mid-transfer discards the pending write without committing it.

Decomposition:
- Package general_register_pkg holds:
  - typedef register_index_t (3 bits), byte_enable_t (4 bits);
  - enum access_size_e {SIZE_8, SIZE_16, SIZE_32};
  - function decode_access_size;
  - constants for EAX..EDI indices.
- Sub-module general_register_lane_map (combinational): code/w/w_in_instruction/size/data -> index, byte_enable, aligned data. One instance per requester plus one for the query path (data tied 0).

Test Plan:
- Req0 only: code=4, w=0, w_in=1, data=0x000000A5 -> next cycle we=1, index=0, be=0010, data=0x0000A500.
- Both requesters valid for 4 cycles, no stall -> grants alternate 0,1,0,1; one write per cycle; order visible at rf_write_*.
- Stage holds a write; rf_write_stall=1 for 3 cycles with both requesters valid -> req_ready=0, outputs stable, pointer unchanged; stall drops -> same requester accepted, write committed next cycle.
- Pending 32-bit write to index 2 (EDX): query code=2, full -> busy=1; query code=6, byte (DH) -> busy=1; query code=3 -> busy=0. Pending AH write: query AL -> busy=0.
- 16-bit write (w_in=0, op32=0), code=7, data=0x12345678 -> index=7, be=0011, data=0x00005678.
- reset_n low while stage_valid=1 and stalled -> immediately we=0, be=0, data=0; after release requester 0 has priority.
